// File: rtl/div_pkg.sv
// Shared definitions for the pipelined 8-bit divider and its result collector.
package div_pkg;

  // Operand/result width of the divider datapath.
  localparam int DIV_W = 8;

  // Default sequence-tag width used by the result bundle.
  localparam int DIV_SEQ_W = 8;

  // One tagged divider result as it is held in the collector FIFO.
  typedef struct packed {
    logic [DIV_SEQ_W-1:0] seq;
    logic [DIV_W-1:0]     quotient;
    logic [DIV_W-1:0]     remainder;
  } div_result_t;

  // Bit width of one stored result entry.
  localparam int DIV_ENTRY_W = $bits(div_result_t);

  // Ceiling log2, with a floor of 1 so that a 1-entry structure still gets an address bit.
  function automatic int div_clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_fifo_mem.sv
// Register-array storage for the result FIFO: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module div_fifo_mem
  import div_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DIV_ENTRY_W,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write the pushed entry into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/div_result_fifo.sv
// Collector for divider result pulses: tags each result with a sequence number,
// buffers it in a small FIFO and presents the head over valid/ready. Results that
// arrive while the FIFO is full and not draining are dropped and counted.
module div_result_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DIV_W-1:0]           in_quotient,
  input  logic [DIV_W-1:0]           in_remainder,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIV_W-1:0]           out_quotient,
  output logic [DIV_W-1:0]           out_remainder,
  output logic [SEQ_W-1:0]           out_seq,
  output logic [div_clog2(DEPTH):0]  count,
  output logic                       full,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  input  logic                       clr_overflow
);

  localparam int AW      = div_clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int ENTRY_W = SEQ_W + 2 * DIV_W;

  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [SEQ_W-1:0] SEQ_ONE  = SEQ_W'(1);

  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [SEQ_W-1:0]   r_seq;
  logic               r_overflow;
  logic [7:0]         r_drop_count;

  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_wr_data;
  logic [ENTRY_W-1:0] w_rd_data;

  // Full and valid come from the registered occupancy only.
  assign w_empty = (r_count == {CW{1'b0}});
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = !w_empty && out_ready;
  assign w_push  = in_valid && (!w_full || w_pop);
  assign w_drop  = in_valid && !w_push;

  // Stored entry carries the tag value before this pulse's increment.
  assign w_wr_data = {r_seq, in_quotient, in_remainder};

  div_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // Pointers, occupancy and sequence counter; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_seq    <= {SEQ_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // Every result pulse consumes a tag, stored or dropped.
      if (in_valid) begin
        r_seq <= r_seq + SEQ_ONE;
      end
    end
  end

  // Sticky overflow and saturating drop counter; a drop outranks a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= 8'h00;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_overflow) begin
        r_drop_count <= 8'h01;
      end else if (r_drop_count != 8'hFF) begin
        r_drop_count <= r_drop_count + 8'h01;
      end
    end else if (clr_overflow) begin
      r_overflow   <= 1'b0;
      r_drop_count <= 8'h00;
    end
  end

  // Show-ahead head entry, forced to zero while the FIFO is empty.
  always_comb begin
    out_seq       = {SEQ_W{1'b0}};
    out_quotient  = {DIV_W{1'b0}};
    out_remainder = {DIV_W{1'b0}};
    if (!w_empty) begin
      out_seq       = w_rd_data[ENTRY_W-1 -: SEQ_W];
      out_quotient  = w_rd_data[2*DIV_W-1 -: DIV_W];
      out_remainder = w_rd_data[DIV_W-1:0];
    end else begin
      out_seq       = {SEQ_W{1'b0}};
      out_quotient  = {DIV_W{1'b0}};
      out_remainder = {DIV_W{1'b0}};
    end
  end

  assign out_valid  = !w_empty;
  assign count      = r_count;
  assign full       = w_full;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_div_result_fifo.sv
// Directed bench for div_result_fifo (DEPTH=4, SEQ_W=8).
module tb_div_result_fifo;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_quotient;
  logic [7:0] in_remainder;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_quotient;
  logic [7:0] out_remainder;
  logic [7:0] out_seq;
  logic [2:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] drop_count;
  logic       clr_overflow;

  int checks;
  int errors;

  div_result_fifo #(.DEPTH(4), .SEQ_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_quotient   (in_quotient),
    .in_remainder  (in_remainder),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_seq       (out_seq),
    .count         (count),
    .full          (full),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .clr_overflow  (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr_overflow = 1'b0;
    in_quotient = 8'd0;
    in_remainder = 8'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] q, input logic [7:0] r);
    in_valid = 1'b1;
    in_quotient = q;
    in_remainder = r;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0d exp 0", full); end
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL reset_ovf got %0d/%0d exp 0/0", overflow, drop_count); end
    checks++; if ({out_seq, out_quotient, out_remainder} !== 24'd0) begin errors++; $display("FAIL reset_out got %h exp 0", {out_seq, out_quotient, out_remainder}); end
  endtask

  task automatic test_single();
    do_reset();
    pulse(8'd33, 8'd1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0d exp 1", out_valid); end
    checks++; if (out_quotient !== 8'd33 || out_remainder !== 8'd1) begin errors++; $display("FAIL single_data got %0d/%0d exp 33/1", out_quotient, out_remainder); end
    checks++; if (out_seq !== 8'd0) begin errors++; $display("FAIL single_seq got %0d exp 0", out_seq); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
    pop_one();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_quotient !== 8'd0) begin errors++; $display("FAIL single_drain got c=%0d v=%0d q=%0d exp 0/0/0", count, out_valid, out_quotient); end
    // out_ready while empty must not disturb anything
    pop_one();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_pop_count got %0d exp 0", count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) pulse(8'(10 + i), 8'(i));
    checks++; if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL fill got f=%0d c=%0d o=%0d exp 1/4/0", full, count, overflow); end
    pulse(8'd99, 8'd9);
    checks++; if (overflow !== 1'b1 || drop_count !== 8'd1 || count !== 3'd4) begin errors++; $display("FAIL drop got o=%0d d=%0d c=%0d exp 1/1/4", overflow, drop_count, count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_seq !== 8'(i) || out_quotient !== 8'(10 + i) || out_remainder !== 8'(i)) begin errors++; $display("FAIL drain_%0d got s=%0d q=%0d r=%0d exp %0d/%0d/%0d", i, out_seq, out_quotient, out_remainder, i, 10 + i, i); end
      pop_one();
    end
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drained got v=%0d c=%0d exp 0/0", out_valid, count); end
    pulse(8'd7, 8'd0);
    checks++; if (out_seq !== 8'd5 || out_quotient !== 8'd7) begin errors++; $display("FAIL seq_after_drop got s=%0d q=%0d exp 5/7", out_seq, out_quotient); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) pulse(8'(20 + i), 8'd0);
    in_valid = 1'b1; in_quotient = 8'd77; in_remainder = 8'd7; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd4 || overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL fullpp got c=%0d o=%0d d=%0d exp 4/0/0", count, overflow, drop_count); end
    checks++; if (out_seq !== 8'd1 || out_quotient !== 8'd21) begin errors++; $display("FAIL fullpp_head got s=%0d q=%0d exp 1/21", out_seq, out_quotient); end
    for (int i = 0; i < 3; i++) pop_one();
    checks++; if (out_seq !== 8'd4 || out_quotient !== 8'd77 || out_remainder !== 8'd7) begin errors++; $display("FAIL fullpp_tail got s=%0d q=%0d r=%0d exp 4/77/7", out_seq, out_quotient, out_remainder); end
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    in_valid = 1'b1; in_quotient = 8'd5; in_remainder = 8'd2; out_ready = 1'b1;
    tick();
    checks++; if (count !== 3'd1 || out_quotient !== 8'd5 || out_seq !== 8'd0) begin errors++; $display("FAIL emptypp got c=%0d q=%0d s=%0d exp 1/5/0", count, out_quotient, out_seq); end
    in_quotient = 8'd6; in_remainder = 8'd3;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd1 || out_quotient !== 8'd6 || out_seq !== 8'd1) begin errors++; $display("FAIL onepp got c=%0d q=%0d s=%0d exp 1/6/1", count, out_quotient, out_seq); end
  endtask

  task automatic test_drops();
    do_reset();
    for (int i = 0; i < 4; i++) pulse(8'(i), 8'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    checks++; if (drop_count !== 8'hFF || overflow !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL saturate got d=%0d o=%0d c=%0d exp 255/1/4", drop_count, overflow, count); end
    clr_overflow = 1'b1;
    tick();
    checks++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin errors++; $display("FAIL clr_vs_drop got o=%0d d=%0d exp 1/1", overflow, drop_count); end
    in_valid = 1'b0;
    tick();
    clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL clr got o=%0d d=%0d exp 0/0", overflow, drop_count); end
    checks++; if (out_seq !== 8'd0 || count !== 3'd4) begin errors++; $display("FAIL drops_head got s=%0d c=%0d exp 0/4", out_seq, count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) pulse(8'(40 + i), 8'd1);
    pop_one();
    checks++; if (count !== 3'd3 || overflow !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset got c=%0d o=%0d v=%0d exp 3/1/1", count, overflow, out_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL async_reset got v=%0d c=%0d o=%0d f=%0d exp 0/0/0/0", out_valid, count, overflow, full); end
    checks++; if ({out_seq, out_quotient, out_remainder} !== 24'd0 || drop_count !== 8'd0) begin errors++; $display("FAIL async_reset_out got %h d=%0d exp 0/0", {out_seq, out_quotient, out_remainder}, drop_count); end
    tick();
    reset = 1'b0;
    pulse(8'd88, 8'd2);
    checks++; if (out_seq !== 8'd0 || out_quotient !== 8'd88) begin errors++; $display("FAIL post_reset_seq got s=%0d q=%0d exp 0/88", out_seq, out_quotient); end
  endtask

  task automatic test_seq_wrap();
    int bad;
    do_reset();
    bad = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 256; k++) begin
      in_quotient = 8'(k);
      in_remainder = 8'(255 - k);
      tick();
      if (out_seq !== 8'(k) || out_quotient !== 8'(k) || count !== 3'd1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stream got %0d bad cycles exp 0", bad); end
    checks++; if (out_seq !== 8'd255) begin errors++; $display("FAIL seq_255 got %0d exp 255", out_seq); end
    in_quotient = 8'd123;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (out_seq !== 8'd0 || out_quotient !== 8'd123 || count !== 3'd1) begin errors++; $display("FAIL seq_wrap got s=%0d q=%0d c=%0d exp 0/123/1", out_seq, out_quotient, count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr_overflow = 1'b0;
    in_quotient = 8'd0;
    in_remainder = 8'd0;
    #3;
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_drops();
    test_reset_mid();
    test_seq_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
